// File: rtl/snd_frame_buffer_if.sv
// snd_frame_buffer_if: sample-write, frame-read, control and status bundle for snd_frame_buffer.
// The slave modport is the buffer; the master modport is the surrounding audio/PWM logic.
interface snd_frame_buffer_if #(
  parameter int DATA_W = 16,
  parameter int NCH    = 2,
  parameter int DEPTH  = 2048,
  parameter int WAIT_W = 3
);
  localparam int AW = $clog2(DEPTH);

  logic [1:0]            COMMAND;
  logic [WAIT_W-1:0]     fir_wait;
  logic [DATA_W-1:0]     din;
  logic                  ppBUF_WR;
  logic                  ppBUF_WREADY;
  logic                  pwmBUF_WREADY;
  logic [NCH*DATA_W-1:0] dout;
  logic                  dout_valid;
  logic                  ppBUF_RREADY;
  logic [AW:0]           data_count;
  logic                  OVER;
  logic                  UNDER;

  modport slave (
    input  COMMAND, fir_wait, din, ppBUF_WR, pwmBUF_WREADY,
    output ppBUF_WREADY, dout, dout_valid, ppBUF_RREADY, data_count, OVER, UNDER
  );

  modport master (
    output COMMAND, fir_wait, din, ppBUF_WR, pwmBUF_WREADY,
    input  ppBUF_WREADY, dout, dout_valid, ppBUF_RREADY, data_count, OVER, UNDER
  );
endinterface

// File: rtl/snd_frame_buffer.sv
// snd_frame_buffer: multichannel sample FIFO presenting whole paced frames to the PWM stage.
// Optional SND_FRAME_HOLD_EN: a starved pacing tick re-emits the last frame with dout_valid.
module snd_frame_buffer #(
  parameter int DATA_W    = 16,
  parameter int NCH       = 2,
  parameter int DEPTH     = 2048,
  parameter int WR_MARGIN = 3,
  parameter int WAIT_W    = 3
) (
  input logic               ACLK,
  input logic               ARESETN,
  snd_frame_buffer_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [AW:0]   C_DEPTH = (AW+1)'(DEPTH);
  localparam logic [AW:0]   C_HIWAT = (AW+1)'(DEPTH - WR_MARGIN);
  localparam logic [AW:0]   C_NCH   = (AW+1)'(NCH);
  localparam logic [IW-1:0] C_LAST  = IW'(NCH - 1);
`ifdef SND_FRAME_HOLD_EN
  localparam logic C_HOLD = 1'b1;
`else
  localparam logic C_HOLD = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_GATHER  = 2'd1,
    S_PRESENT = 2'd2
  } state_t;

  state_t                r_state, w_state_nxt;
  logic [IW-1:0]         r_gidx, w_gidx_nxt;
  logic [1:0]            r_com;
  logic [WAIT_W-1:0]     r_cnt;
  logic [AW-1:0]         r_wr_ptr, r_rd_ptr;
  logic [AW:0]           r_count, w_count_nxt;
  logic [DATA_W-1:0]     r_mem [DEPTH];
  logic [DATA_W-1:0]     r_rd_data;
  logic                  r_rd_vld;
  logic [IW-1:0]         r_rd_idx;
  logic [NCH*DATA_W-1:0] r_frame, w_frame, r_dout;
  logic                  r_dout_valid, r_wready, r_rready, r_over, r_under;
  logic                  w_flush, w_run, w_tick, w_full, w_wr, w_rd, w_req, w_start, w_starve;

  // Decode registered command, pacing tick and the accepted write/read strobes.
  always_comb begin
    w_flush  = (r_com == 2'b11);
    w_run    = (r_com == 2'b01);
    w_tick   = (r_cnt == {WAIT_W{1'b0}});
    w_full   = (r_count == C_DEPTH);
    w_wr     = bus.ppBUF_WR && !w_full && !w_flush;
    w_rd     = (r_state == S_GATHER) && !w_flush;
    w_req    = w_tick && w_run && bus.pwmBUF_WREADY && (r_state == S_IDLE);
    w_start  = w_req && (r_count >= C_NCH);
    w_starve = w_req && (r_count < C_NCH);
  end

  // Next word count: a simultaneous read and write cancel out.
  always_comb begin
    w_count_nxt = r_count;
    if (w_flush) begin
      w_count_nxt = {(AW+1){1'b0}};
    end else begin
      case ({w_wr, w_rd})
        2'b10:   w_count_nxt = r_count + (AW+1)'(1'b1);
        2'b01:   w_count_nxt = r_count - (AW+1)'(1'b1);
        default: w_count_nxt = r_count;
      endcase
    end
  end

  // Command register and pacing counter; the tick is the cycle where the counter sits at zero.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_com <= 2'b00;
      r_cnt <= {WAIT_W{1'b0}};
    end else begin
      r_com <= bus.COMMAND;
      if (!w_run)
        r_cnt <= {WAIT_W{1'b0}};
      else if (w_tick)
        r_cnt <= WAIT_W'(1'b1);
      else if (r_cnt >= bus.fir_wait)
        r_cnt <= {WAIT_W{1'b0}};
      else
        r_cnt <= r_cnt + WAIT_W'(1'b1);
    end
  end

  // Pointers, count and sticky/level status flags.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_wr_ptr <= {AW{1'b0}};
      r_rd_ptr <= {AW{1'b0}};
      r_count  <= {(AW+1){1'b0}};
      r_wready <= 1'b0;
      r_rready <= 1'b0;
      r_over   <= 1'b0;
      r_under  <= 1'b0;
    end else begin
      r_count  <= w_count_nxt;
      r_wready <= (w_count_nxt < C_HIWAT);
      r_rready <= (w_count_nxt >= C_NCH);
      if (w_flush) begin
        r_wr_ptr <= {AW{1'b0}};
        r_rd_ptr <= {AW{1'b0}};
        r_over   <= 1'b0;
        r_under  <= 1'b0;
      end else begin
        if (w_wr)
          r_wr_ptr <= r_wr_ptr + AW'(1'b1);
        if (w_rd)
          r_rd_ptr <= r_rd_ptr + AW'(1'b1);
        if (bus.ppBUF_WR && w_full)
          r_over <= 1'b1;
        if (w_starve)
          r_under <= 1'b1;
      end
    end
  end

  // Sample RAM with a registered read port.
  always_ff @(posedge ACLK) begin
    if (w_wr)
      r_mem[r_wr_ptr] <= bus.din;
    if (w_rd)
      r_rd_data <= r_mem[r_rd_ptr];
  end

  // Read FSM state register.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_state <= S_IDLE;
      r_gidx  <= {IW{1'b0}};
    end else begin
      r_state <= w_state_nxt;
      r_gidx  <= w_gidx_nxt;
    end
  end

  // Read FSM next state: flush aborts any gather, stop lets a started gather finish.
  always_comb begin
    w_state_nxt = r_state;
    w_gidx_nxt  = r_gidx;
    if (w_flush) begin
      w_state_nxt = S_IDLE;
      w_gidx_nxt  = {IW{1'b0}};
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            w_state_nxt = S_GATHER;
            w_gidx_nxt  = {IW{1'b0}};
          end else if (w_starve && C_HOLD) begin
            w_state_nxt = S_PRESENT;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
        S_GATHER: begin
          if (r_gidx == C_LAST)
            w_state_nxt = S_PRESENT;
          else
            w_gidx_nxt = r_gidx + IW'(1'b1);
        end
        S_PRESENT: w_state_nxt = S_IDLE;
        default:   w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Merge the word returning from RAM into its channel slot of the staging frame.
  always_comb begin
    w_frame = r_frame;
    for (int i = 0; i < NCH; i++) begin
      if (r_rd_vld && (r_rd_idx == IW'(i)))
        w_frame[i*DATA_W +: DATA_W] = r_rd_data;
      else
        w_frame[i*DATA_W +: DATA_W] = r_frame[i*DATA_W +: DATA_W];
    end
  end

  // Staging frame and output frame; dout only changes together with the valid strobe.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_rd_vld     <= 1'b0;
      r_rd_idx     <= {IW{1'b0}};
      r_frame      <= {(NCH*DATA_W){1'b0}};
      r_dout       <= {(NCH*DATA_W){1'b0}};
      r_dout_valid <= 1'b0;
    end else begin
      r_rd_vld <= w_rd;
      r_rd_idx <= r_gidx;
      if (w_flush) begin
        r_frame      <= {(NCH*DATA_W){1'b0}};
        r_dout_valid <= 1'b0;
      end else begin
        r_frame      <= w_frame;
        r_dout_valid <= (r_state == S_PRESENT);
        if (r_state == S_PRESENT)
          r_dout <= w_frame;
      end
    end
  end

  assign bus.dout         = r_dout;
  assign bus.dout_valid   = r_dout_valid;
  assign bus.ppBUF_WREADY = r_wready;
  assign bus.ppBUF_RREADY = r_rready;
  assign bus.data_count   = r_count;
  assign bus.OVER         = r_over;
  assign bus.UNDER        = r_under;
endmodule

// File: tb/tb_snd_frame_buffer.sv
// tb_snd_frame_buffer: scoreboard bench for snd_frame_buffer with DEPTH=16, NCH=2.
// Written words are queued in a model; every dout_valid pops one frame and compares it.
module tb_snd_frame_buffer;
  localparam int DATA_W    = 16;
  localparam int NCH       = 2;
  localparam int DEPTH     = 16;
  localparam int WR_MARGIN = 3;
  localparam int WAIT_W    = 3;

  logic ACLK = 1'b0;
  logic ARESETN;
  int   n_run  = 0;
  int   n_fail = 0;
  int   cyc    = 0;
  logic [DATA_W-1:0]     mdl_q[$];
  logic [NCH*DATA_W-1:0] hold_frame = '0;
  int   vcyc[$];

  snd_frame_buffer_if #(.DATA_W(DATA_W), .NCH(NCH), .DEPTH(DEPTH), .WAIT_W(WAIT_W)) bus ();

  snd_frame_buffer #(
    .DATA_W(DATA_W), .NCH(NCH), .DEPTH(DEPTH), .WR_MARGIN(WR_MARGIN), .WAIT_W(WAIT_W)
  ) dut (
    .ACLK   (ACLK),
    .ARESETN(ARESETN),
    .bus    (bus)
  );

  always #5 ACLK = ~ACLK;
  always @(posedge ACLK) cyc <= cyc + 1;

  // Frame monitor: each pulse must carry the next two queued words (word 0 in the low half).
  always @(negedge ACLK) begin
    logic [NCH*DATA_W-1:0] exp_f;
    if (ARESETN === 1'b1 && bus.dout_valid === 1'b1) begin
      vcyc.push_back(cyc);
      n_run++;
      if (mdl_q.size() >= NCH) begin
        exp_f = {mdl_q[1], mdl_q[0]};
        void'(mdl_q.pop_front());
        void'(mdl_q.pop_front());
        hold_frame = exp_f;
        if (bus.dout !== exp_f) begin
          n_fail++;
          $display("FAIL frame_data: dout=%h expected %h at cycle %0d", bus.dout, exp_f, cyc);
        end
      end else begin
`ifdef SND_FRAME_HOLD_EN
        if (bus.dout !== hold_frame) begin
          n_fail++;
          $display("FAIL hold_frame: dout=%h expected %h at cycle %0d", bus.dout, hold_frame, cyc);
        end
`else
        n_fail++;
        $display("FAIL unexpected_valid: dout_valid=1 dout=%h, expected no frame (cycle %0d)",
                 bus.dout, cyc);
`endif
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic step(input int n);
    repeat (n) begin
      @(negedge ACLK);
      #1;
    end
  endtask

  task automatic wr(input logic [DATA_W-1:0] d);
    bus.din      = d;
    bus.ppBUF_WR = 1'b1;
    step(1);
    bus.ppBUF_WR = 1'b0;
    if (mdl_q.size() < DEPTH) mdl_q.push_back(d);
  endtask

  task automatic test_reset();
    ARESETN           = 1'b0;
    bus.COMMAND       = 2'b00;
    bus.fir_wait      = 3'd3;
    bus.din           = 16'h0000;
    bus.ppBUF_WR      = 1'b0;
    bus.pwmBUF_WREADY = 1'b1;
    step(3);
    n_run++;
    if (bus.dout !== 32'h0 || bus.dout_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_dout: dout=%h valid=%b expected 0/0", bus.dout, bus.dout_valid);
    end
    n_run++;
    if (bus.data_count !== 5'd0 || bus.OVER !== 1'b0 || bus.UNDER !== 1'b0) begin
      n_fail++; $display("FAIL reset_status: count=%0d OVER=%b UNDER=%b expected 0/0/0",
                         bus.data_count, bus.OVER, bus.UNDER);
    end
    n_run++;
    if (bus.ppBUF_WREADY !== 1'b0 || bus.ppBUF_RREADY !== 1'b0) begin
      n_fail++; $display("FAIL reset_ready: wready=%b rready=%b expected 0/0",
                         bus.ppBUF_WREADY, bus.ppBUF_RREADY);
    end
    ARESETN = 1'b1;
    step(1);
    n_run++;
    if (bus.ppBUF_WREADY !== 1'b1 || bus.ppBUF_RREADY !== 1'b0) begin
      n_fail++; $display("FAIL idle_ready: wready=%b rready=%b expected 1/0",
                         bus.ppBUF_WREADY, bus.ppBUF_RREADY);
    end
  endtask

  task automatic test_frame_order();
    int k;
    bus.fir_wait = 3'd3;
    wr(16'h1111); wr(16'h2222); wr(16'h3333); wr(16'h4444);
    n_run++;
    if (bus.data_count !== 5'd4 || bus.ppBUF_RREADY !== 1'b1) begin
      n_fail++; $display("FAIL fill4: count=%0d rready=%b expected 4/1", bus.data_count, bus.ppBUF_RREADY);
    end
    vcyc.delete();
    k = cyc;
    bus.COMMAND = 2'b01;
    step(6);
    bus.COMMAND = 2'b00;
    for (int i = 0; i < 20 && vcyc.size() < 2; i++) step(1);
    n_run++;
    if (vcyc.size() != 2) begin
      n_fail++; $display("FAIL frame_count: got %0d pulses, expected 2", vcyc.size());
    end else begin
      n_run++;
      if (vcyc[0] != k + 5) begin
        n_fail++; $display("FAIL tick_latency: pulse at cycle %0d, expected %0d", vcyc[0], k + 5);
      end
      n_run++;
      if (vcyc[1] - vcyc[0] != 4) begin
        n_fail++; $display("FAIL frame_spacing: %0d cycles, expected 4", vcyc[1] - vcyc[0]);
      end
    end
    step(2);
    n_run++;
    if (bus.dout !== 32'h44443333 || bus.dout_valid !== 1'b0) begin
      n_fail++; $display("FAIL dout_hold: dout=%h valid=%b expected 44443333/0", bus.dout, bus.dout_valid);
    end
    n_run++;
    if (bus.data_count !== 5'd0 || bus.UNDER !== 1'b0) begin
      n_fail++; $display("FAIL after_frames: count=%0d UNDER=%b expected 0/0", bus.data_count, bus.UNDER);
    end
  endtask

  task automatic test_async_reset();
    wr(16'hA0A0); wr(16'hB0B0);
    bus.COMMAND = 2'b01;
    step(2);
    n_run++;
    if (bus.dout !== 32'h44443333) begin
      n_fail++; $display("FAIL pre_reset_dout: dout=%h expected 44443333", bus.dout);
    end
    #1 ARESETN = 1'b0;
    #1;
    n_run++;
    if (bus.dout !== 32'h0 || bus.dout_valid !== 1'b0 || bus.data_count !== 5'd0 ||
        bus.ppBUF_WREADY !== 1'b0 || bus.ppBUF_RREADY !== 1'b0) begin
      n_fail++; $display("FAIL async_reset: dout=%h valid=%b count=%0d wr=%b rr=%b expected all 0",
                         bus.dout, bus.dout_valid, bus.data_count, bus.ppBUF_WREADY, bus.ppBUF_RREADY);
    end
    bus.COMMAND = 2'b00;
    mdl_q.delete();
    hold_frame = '0;
    step(1);
    ARESETN = 1'b1;
    step(1);
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 12; i++) wr(DATA_W'(i) + 16'h0C00);
    n_run++;
    if (bus.data_count !== 5'd12 || bus.ppBUF_WREADY !== 1'b1) begin
      n_fail++; $display("FAIL count12: count=%0d wready=%b expected 12/1", bus.data_count, bus.ppBUF_WREADY);
    end
    wr(16'h0C0C);
    n_run++;
    if (bus.data_count !== 5'd13 || bus.ppBUF_WREADY !== 1'b0) begin
      n_fail++; $display("FAIL margin13: count=%0d wready=%b expected 13/0", bus.data_count, bus.ppBUF_WREADY);
    end
    for (int i = 13; i < 16; i++) wr(DATA_W'(i) + 16'h0C00);
    n_run++;
    if (bus.data_count !== 5'd16 || bus.OVER !== 1'b0) begin
      n_fail++; $display("FAIL full16: count=%0d OVER=%b expected 16/0", bus.data_count, bus.OVER);
    end
    wr(16'hDEAD);
    n_run++;
    if (bus.data_count !== 5'd16 || bus.OVER !== 1'b1) begin
      n_fail++; $display("FAIL overflow: count=%0d OVER=%b expected 16/1", bus.data_count, bus.OVER);
    end
    bus.fir_wait = 3'd0;
    bus.COMMAND  = 2'b01;
    for (int i = 0; i < 200 && mdl_q.size() != 0; i++) step(1);
    bus.COMMAND = 2'b00;
    n_run++;
    if (mdl_q.size() != 0) begin
      n_fail++; $display("FAIL readback_timeout: %0d words unread, expected 0", mdl_q.size());
    end
    step(3);
    n_run++;
    if (bus.data_count !== 5'd0) begin
      n_fail++; $display("FAIL readback_count: count=%0d expected 0", bus.data_count);
    end
  endtask

  task automatic test_flush();
    n_run++;
    if (bus.OVER !== 1'b1) begin
      n_fail++; $display("FAIL over_sticky: OVER=%b expected 1", bus.OVER);
    end
    for (int i = 0; i < 10; i++) wr(DATA_W'(i) + 16'hF000);
    n_run++;
    if (bus.data_count !== 5'd10) begin
      n_fail++; $display("FAIL fill10: count=%0d expected 10", bus.data_count);
    end
    bus.COMMAND = 2'b11;
    step(1);
    bus.COMMAND = 2'b00;
    step(1);
    mdl_q.delete();
    hold_frame = '0;
    n_run++;
    if (bus.data_count !== 5'd0 || bus.ppBUF_RREADY !== 1'b0) begin
      n_fail++; $display("FAIL flush_count: count=%0d rready=%b expected 0/0", bus.data_count, bus.ppBUF_RREADY);
    end
    n_run++;
    if (bus.OVER !== 1'b0 || bus.UNDER !== 1'b0) begin
      n_fail++; $display("FAIL flush_flags: OVER=%b UNDER=%b expected 0/0", bus.OVER, bus.UNDER);
    end
  endtask

  task automatic test_starve();
    int v0;
    wr(16'h5A5A);
    n_run++;
    if (bus.UNDER !== 1'b0) begin
      n_fail++; $display("FAIL under_pre: UNDER=%b expected 0", bus.UNDER);
    end
    v0 = vcyc.size();
    bus.fir_wait = 3'd3;
    bus.COMMAND  = 2'b01;
    step(2);
    n_run++;
    if (bus.UNDER !== 1'b1) begin
      n_fail++; $display("FAIL starve_under: UNDER=%b expected 1", bus.UNDER);
    end
    step(6);
    bus.COMMAND = 2'b00;
    step(3);
    n_run++;
`ifdef SND_FRAME_HOLD_EN
    if (vcyc.size() == v0) begin
      n_fail++; $display("FAIL hold_pulse: got %0d pulses, expected at least 1", vcyc.size() - v0);
    end
`else
    if (vcyc.size() != v0) begin
      n_fail++; $display("FAIL starve_valid: got %0d pulses, expected 0", vcyc.size() - v0);
    end
`endif
    n_run++;
    if (bus.data_count !== 5'd1) begin
      n_fail++; $display("FAIL partial_kept: count=%0d expected 1", bus.data_count);
    end
    bus.COMMAND = 2'b11;
    step(1);
    bus.COMMAND = 2'b00;
    step(1);
    mdl_q.delete();
    hold_frame = '0;
  endtask

  task automatic test_backpressure();
    int v0;
    for (int i = 0; i < 4; i++) wr(DATA_W'(i) + 16'hB100);
    v0 = vcyc.size();
    bus.pwmBUF_WREADY = 1'b0;
    bus.fir_wait      = 3'd1;
    bus.COMMAND       = 2'b01;
    step(20);
    n_run++;
    if (vcyc.size() != v0 || bus.UNDER !== 1'b0) begin
      n_fail++; $display("FAIL backpressure: pulses=%0d UNDER=%b expected 0/0", vcyc.size() - v0, bus.UNDER);
    end
    n_run++;
    if (bus.data_count !== 5'd4) begin
      n_fail++; $display("FAIL bp_count: count=%0d expected 4", bus.data_count);
    end
    bus.pwmBUF_WREADY = 1'b1;
    for (int i = 0; i < 40 && mdl_q.size() != 0; i++) step(1);
    bus.COMMAND = 2'b00;
    step(3);
    n_run++;
    if (mdl_q.size() != 0 || bus.data_count !== 5'd0) begin
      n_fail++; $display("FAIL bp_release: unread=%0d count=%0d expected 0/0", mdl_q.size(), bus.data_count);
    end
  endtask

  task automatic test_back_to_back();
    int diff;
    wr(16'h7000); wr(16'h7001);
    bus.fir_wait = 3'd1;
    bus.COMMAND  = 2'b01;
    for (int i = 2; i < 22; i++) begin
      bus.din      = DATA_W'(i) + 16'h7000;
      bus.ppBUF_WR = 1'b1;
      step(1);
      if (mdl_q.size() < DEPTH) mdl_q.push_back(DATA_W'(i) + 16'h7000);
    end
    bus.ppBUF_WR = 1'b0;
    diff = mdl_q.size() - int'(bus.data_count);
    n_run++;
    if (diff < 0 || diff > NCH) begin
      n_fail++; $display("FAIL concurrent_count: count=%0d model=%0d expected within %0d",
                         bus.data_count, mdl_q.size(), NCH);
    end
    for (int i = 0; i < 100 && mdl_q.size() != 0; i++) step(1);
    bus.COMMAND = 2'b00;
    step(3);
    n_run++;
    if (mdl_q.size() != 0 || bus.data_count !== 5'd0) begin
      n_fail++; $display("FAIL wrap_drain: unread=%0d count=%0d expected 0/0", mdl_q.size(), bus.data_count);
    end
  endtask

  initial begin
    test_reset();
    test_frame_order();
    test_async_reset();
    test_overflow();
    test_flush();
    test_starve();
    test_backpressure();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
